proc_seq: RTL

PROC_SEQ -- requirements
Module: proc_seq

---
 rtl/proc_pkg.sv | 26 ++
 rtl/retire_cnt.sv | 27 ++
 rtl/proc_seq.sv | 139 +++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared encodings for the instruction sequencer: FSM states, PC source select
// codes and the exception vector address.
package proc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_EXC    = 3'd6,
        ST_HALT   = 3'd7
    } state_e;

    // Code 3 is reserved and never driven.
    typedef enum logic [1:0] {
        PC_SEL_NEXT = 2'd0,
        PC_SEL_EPC  = 2'd1,
        PC_SEL_EXC  = 2'd2
    } pc_sel_e;

    localparam logic [15:0] EXC_VECTOR = 16'h0002;
    localparam int          RETIRE_W   = 16;

endpackage

// File: rtl/retire_cnt.sv
// Retired-instruction counter: increments on enable, wraps at full scale,
// cleared asynchronously by the active-low reset.
module retire_cnt #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign count_d = en_i ? count_q + W'(1) : count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/proc_seq.sv
// Multi-cycle instruction sequencer: steps fetch/decode/execute/memory/writeback
// and raises the datapath write strobes, counting every retired instruction.
//
//   state  | meaning
//   IDLE   | waiting for start after reset
//   FETCH  | instruction memory request held until imem_done
//   DECODE | one cycle for decode flags to settle
//   EXEC   | resolve exception / rti / halt / mem / wb / ALU
//   MEM    | data memory request held until dmem_done
//   WB     | register file write, PC update, retire
//   EXC    | EPC capture, PC to exception vector, retire
//   HALT   | stopped until reset
module proc_seq
    import proc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_mem,
    input  logic        is_wb,
    input  logic        is_halt,
    input  logic        exception,
    input  logic        rti,
    input  logic        imem_done,
    input  logic        dmem_done,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic        epc_we,
    output logic [1:0]  pc_sel,
    output logic [2:0]  state,
    output logic        halted,
    output logic [15:0] retired
);

    state_e  state_q;
    pc_sel_e pc_sel_c;
    logic    ir_we_c;
    logic    pc_we_c;
    logic    rf_we_c;
    logic    epc_we_c;
    logic    retire_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_done) state_q <= ST_DECODE;
                end
                ST_DECODE: state_q <= ST_EXEC;
                ST_EXEC: begin
                    if (exception)    state_q <= ST_EXC;
                    else if (rti)     state_q <= ST_FETCH;
                    else if (is_halt) state_q <= ST_HALT;
                    else if (is_mem)  state_q <= ST_MEM;
                    else if (is_wb)   state_q <= ST_WB;
                    else              state_q <= ST_FETCH;
                end
                ST_MEM: begin
                    if (dmem_done) state_q <= is_wb ? ST_WB : ST_FETCH;
                end
                ST_WB:   state_q <= ST_FETCH;
                ST_EXC:  state_q <= ST_FETCH;
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Strobes are Mealy so a done strobe is acted on in the cycle it arrives.
    always_comb begin
        pc_sel_c = PC_SEL_NEXT;
        ir_we_c  = 1'b0;
        pc_we_c  = 1'b0;
        rf_we_c  = 1'b0;
        epc_we_c = 1'b0;
        retire_c = 1'b0;
        case (state_q)
            ST_FETCH: ir_we_c = imem_done;
            ST_EXEC: begin
                if (!exception) begin
                    if (rti) begin
                        pc_we_c  = 1'b1;
                        pc_sel_c = PC_SEL_EPC;
                        retire_c = 1'b1;
                    end else if (!is_halt && !is_mem && !is_wb) begin
                        pc_we_c  = 1'b1;
                        retire_c = 1'b1;
                    end
                end
            end
            ST_MEM: begin
                if (dmem_done && !is_wb) begin
                    pc_we_c  = 1'b1;
                    retire_c = 1'b1;
                end
            end
            ST_WB: begin
                rf_we_c  = 1'b1;
                pc_we_c  = 1'b1;
                retire_c = 1'b1;
            end
            ST_EXC: begin
                epc_we_c = 1'b1;
                pc_we_c  = 1'b1;
                pc_sel_c = PC_SEL_EXC;
                retire_c = 1'b1;
            end
            default: ;
        endcase
    end

    retire_cnt #(
        .W (RETIRE_W)
    ) u_cnt (
        .clk_i   (clk),
        .rst_ni  (rst),
        .en_i    (retire_c),
        .count_o (retired)
    );

    assign imem_req = (state_q == ST_FETCH);
    assign dmem_req = (state_q == ST_MEM);
    assign halted   = (state_q == ST_HALT);
    assign state    = state_q;
    assign pc_sel   = pc_sel_c;
    assign ir_we    = ir_we_c;
    assign pc_we    = pc_we_c;
    assign rf_we    = rf_we_c;
    assign epc_we   = epc_we_c;

endmodule
